// File: rtl/div_ctrl.sv
`default_nettype none
// div_ctrl: DIV/DIVU/REM/REMU front end for the iterative unsigned divider.
// Define DIV_CTRL_FASTPATH_EN to resolve divide-by-zero and signed overflow without the divider.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_req_o,
  output logic            div_is_q_o,
  output logic            div_flush_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [XLEN-1:0] raw;
  logic            neg_q;
  logic            neg_r;

  logic            is_signed;
  logic            rs2_zero;
  logic            acc_neg_q;
  logic            acc_neg_r;
  logic            fast_hit;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fast_raw;

  always_comb begin
    is_signed = ~op_i[0];
    rs2_zero  = (rs2_i == '0);
    acc_neg_q = is_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) & ~rs2_zero;
    acc_neg_r = is_signed & rs1_i[XLEN-1];
    abs_a     = (is_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    abs_b     = (is_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
`ifdef DIV_CTRL_FASTPATH_EN
    fast_hit  = rs2_zero | (is_signed & (rs1_i == MIN_NEG) & (&rs2_i));
    // Unsigned raw value that FIX's sign correction turns into the final answer
    if (rs2_zero) begin
      fast_raw = op_i[1] ? abs_a : '1;
    end else begin
      fast_raw = op_i[1] ? '0 : abs_a;
    end
`else
    fast_hit  = 1'b0;
    fast_raw  = MIN_NEG & '0;
`endif
  end

  assign busy_o      = (state != IDLE);
  assign div_flush_o = flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      raw        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result_o   <= '0;
      valid_o    <= 1'b0;
      div_req_o  <= 1'b0;
      div_is_q_o <= 1'b0;
      div_a_o    <= '0;
      div_b_o    <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state     <= IDLE;
        div_req_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_i) begin
              div_a_o    <= abs_a;
              div_b_o    <= abs_b;
              div_is_q_o <= ~op_i[1];
              neg_q      <= acc_neg_q;
              neg_r      <= acc_neg_r;
              raw        <= fast_raw;
              if (fast_hit) begin
                state <= FIX;
              end else begin
                state     <= WAIT;
                div_req_o <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (div_ready_i) begin
              raw       <= div_result_i;
              div_req_o <= 1'b0;
              state     <= FIX;
            end
          end
          FIX: begin
            result_o <= (div_is_q_o ? neg_q : neg_r) ? -raw : raw;
            valid_o  <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage front end for the iterative unsigned divider: accepts RISC-V M-extension DIV/DIVU/REM/REMU operations from the issue logic, converts signed operands to magnitudes, drives the divider's level-sensitive request/ready handshake, applies sign correction to the returned quotient or remainder, and presents a one-cycle result strobe to writeback. It sits between the EXE dispatch and the `div` instance, and stalls the pipeline through `busy_o` while an operation is in flight.

## Interface
- XLEN, 32, datapath width; all operand and result ports are XLEN wide.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  operation request from dispatch; sampled only when `busy_o`=0 and `flush_i`=0.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_i  in  XLEN  dividend.
- rs2_i  in  XLEN  divisor.
- flush_i  in  1  pipeline flush; kills any in-flight operation.
- result_o  out  XLEN  final result; valid while `valid_o`=1, held otherwise.
- valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  controller occupied; dispatch must stall.
- div_a_o  out  XLEN  unsigned dividend magnitude to divider.
- div_b_o  out  XLEN  unsigned divisor magnitude to divider.
- div_req_o  out  1  divider request; level, held until `div_ready_i`.
- div_is_q_o  out  1  1 = quotient wanted (DIV/DIVU), 0 = remainder.
- div_flush_o  out  1  combinational copy of `flush_i`.
- div_result_i  in  XLEN  divider result, valid with `div_ready_i`.
- div_ready_i  in  1  divider one-cycle done strobe.

## Operation
- States: IDLE, WAIT, FIX.
- IDLE: `busy_o`=0. On `valid_i & ~flush_i`, register the operands and the derived values below:
  - signed = ~op_i[0].
  - neg_q = signed & (rs1[31]^rs2[31]) & (rs2≠0).
  - neg_r = signed & rs1[31].
  - mag_a/mag_b = two's-complement absolute value when signed, else the raw operand.
  - |0x80000000| = 0x80000000.
  - Next state WAIT, except a fast-path hit (Configuration), which goes to FIX.
- WAIT: `div_req_o`=1.
  - `div_a_o`, `div_b_o`, `div_is_q_o` are driven from registers and stable for the whole state.
  - On `div_ready_i`: capture `div_result_i`, deassert `div_req_o`, go to FIX.
- FIX: result = neg ? −raw : raw, where neg = neg_q for DIV/DIVU and neg_r for REM/REMU.
  - Register the result into `result_o`, set `valid_o` for the next cycle, go to IDLE.
- Required arithmetic outcomes:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- `busy_o` = state ≠ IDLE.
- Flush: `flush_i` in any state forces IDLE on the next edge.
  - Clears `div_req_o` and suppresses any pending `valid_o`.
  - `result_o` is held.
  - A `div_ready_i` in the same cycle as `flush_i` is ignored.
  - `valid_i` coincident with `flush_i` is not accepted.
- Reset: state IDLE; `result_o`=0; `valid_o`=0; `div_req_o`=0; `div_is_q_o`=0; `div_a_o`=0; `div_b_o`=0.
  - Reset mid-operation discards it; no `valid_o`.

## Timing
- Acceptance edge E0 (IDLE, `valid_i`=1). `div_req_o` is high from the cycle after E0.
- `div_ready_i` sampled at edge Er → FIX in the following cycle, with `div_req_o` already 0.
- `valid_o`/`result_o` are updated at edge Er+1 and visible the cycle after; `valid_o` is exactly one cycle wide.
- `valid_o` is high during IDLE, so a new operation may be accepted in the same cycle.
- `div_req_o` stays low for at least 2 cycles between consecutive requests. This guarantees the divider returns to idle before a new request.
- Fast path: `valid_o` is high 2 cycles after the acceptance cycle, and `div_req_o` never rises.

## Configuration
- DIV_CTRL_FASTPATH_EN defined: divide-by-zero (rs2=0) and signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF) skip WAIT.
  - The result is formed in FIX from constants/rs1.
- Undefined: every operation goes through the divider. The sign-correction rules above yield identical results, at full divider latency.

## Test plan
- DIV 0xFFFFFFEC/3 → 0xFFFFFFFA; REM same operands → 0xFFFFFFFE; `div_a_o`=20, `div_b_o`=3 while `div_req_o`=1.
- DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF; REMU → 0x0000000F.
- DIV 7/0 → 0xFFFFFFFF; REM 0xFFFFFFF9/0 → 0xFFFFFFF9.
  - With FASTPATH_EN: `div_req_o` stays 0 and `valid_o` is high 2 cycles after acceptance.
  - Without: same values via the divider.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0x00000000.
- Assert `flush_i` 10 cycles into WAIT: `div_req_o`=0 and `busy_o`=0 next cycle, no `valid_o`. A following DIVU 100/7 → 14.
- Hold `valid_i` high for two operations (DIVU 9/2, then REMU 9/2):
  - Results 4 then 1, each `valid_o` exactly one cycle.
  - `div_req_o` low for ≥2 cycles between the two requests.
